// File: rtl/idc_sched_pkg.sv
// ============================================================================
// Module  : idc_sched_pkg
// Brief   : Shared types and sizing for the two-requester image-job scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package idc_sched_pkg;

  localparam int N_REQ     = 2;
  localparam int IMG_BEATS = 64;
  localparam int OP_BEATS  = 15;
  localparam int OUT_BEATS = 16;
  localparam int PIX_W     = 7;
  localparam int OP_W      = 4;

  localparam int IN_CNT_W  = $clog2(IMG_BEATS);
  localparam int OUT_CNT_W = $clog2(OUT_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic onehot_idx(input logic [N_REQ-1:0] oh);
    return oh[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/idc_rr_arb.sv
// ============================================================================
// Module  : idc_rr_arb
// Brief   : Two-way round-robin arbiter; priority moves past the served requester.
// Revision: 1.0
// ============================================================================
`default_nettype none

module idc_rr_arb
  import idc_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic [N_REQ-1:0] served,
  output logic [N_REQ-1:0] gnt_next
);

  // r_prio names the requester that wins a tie
  logic r_prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (advance) begin
      r_prio <= served[0];
    end
  end

  always_comb begin
    gnt_next = 2'b00;
    if (r_prio == 1'b0) begin
      if (req[0])      gnt_next = 2'b01;
      else if (req[1]) gnt_next = 2'b10;
    end else begin
      if (req[1])      gnt_next = 2'b10;
      else if (req[0]) gnt_next = 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/idc_sched.sv
// ============================================================================
// Module  : idc_sched
// Brief   : Grants one of two requesters, streams 64 beats into the engine and
//           returns 16 tagged result beats. Optional WAIT timeout under macro
//           IDC_SCHED_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module idc_sched
  import idc_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  input  logic [N_REQ-1:0]         s_valid,
  input  logic [N_REQ*PIX_W-1:0]   s_data,
  input  logic [N_REQ*OP_W-1:0]    s_op,
  output logic                     e_in_valid,
  output logic [PIX_W-1:0]         e_in_data,
  output logic [OP_W-1:0]          e_op,
  input  logic                     e_out_valid,
  input  logic [PIX_W-1:0]         e_out_data,
  output logic                     r_valid,
  output logic [PIX_W-1:0]         r_data,
  output logic                     r_id,
  output logic                     r_last,
  output logic                     busy,
  output logic                     err
);

  state_t                 r_state;
  logic [N_REQ-1:0]       r_gnt;
  logic                   r_e_in_valid;
  logic [PIX_W-1:0]       r_e_in_data;
  logic [OP_W-1:0]        r_e_op;
  logic                   r_r_valid;
  logic [PIX_W-1:0]       r_r_data;
  logic                   r_r_id;
  logic                   r_r_last;
  logic                   r_err;
  logic                   r_discard;
  logic [IN_CNT_W-1:0]    r_in_cnt;
  logic [OUT_CNT_W-1:0]   r_out_cnt;

  logic                   w_sel;
  logic                   w_s_valid;
  logic [PIX_W-1:0]       w_s_data;
  logic [OP_W-1:0]        w_s_op;
  logic [N_REQ-1:0]       w_gnt_next;
  logic                   w_last_out;
  logic                   w_tmo_hit;
  logic                   w_advance;

  // Only the granted requester's stream is ever looked at
  assign w_sel     = onehot_idx(r_gnt);
  assign w_s_valid = s_valid[w_sel];
  assign w_s_data  = w_sel ? s_data[2*PIX_W-1:PIX_W] : s_data[PIX_W-1:0];
  assign w_s_op    = w_sel ? s_op[2*OP_W-1:OP_W]     : s_op[OP_W-1:0];

  assign w_last_out = (r_state == ST_DRAIN) && e_out_valid &&
                      (r_out_cnt == OUT_CNT_W'(OUT_BEATS - 1));
  assign w_advance  = w_last_out || w_tmo_hit;

`ifdef IDC_SCHED_TIMEOUT_EN
  localparam int c_TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [c_TMO_W-1:0] r_tmo_cnt;

  assign w_tmo_hit = (r_state == ST_WAIT) && !e_out_valid &&
                     (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !e_out_valid && !w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  logic w_unused_tmo;

  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
`endif

  idc_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .advance  (w_advance),
    .served   (r_gnt),
    .gnt_next (w_gnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_e_in_valid <= 1'b0;
      r_e_in_data  <= '0;
      r_e_op       <= '0;
      r_r_valid    <= 1'b0;
      r_r_data     <= '0;
      r_r_id       <= 1'b0;
      r_r_last     <= 1'b0;
      r_err        <= 1'b0;
      r_discard    <= 1'b0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_e_in_valid <= 1'b0;
          r_r_valid    <= 1'b0;
          r_r_last     <= 1'b0;
          r_in_cnt     <= '0;
          r_out_cnt    <= '0;
          r_discard    <= 1'b0;
          if (req != '0) begin
            r_gnt   <= w_gnt_next;
            r_state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (w_s_valid) begin
            r_e_in_valid <= 1'b1;
            r_e_in_data  <= w_s_data;
            r_e_op       <= w_s_op;
            r_in_cnt     <= r_in_cnt + IN_CNT_W'(1);
            if (r_in_cnt == IN_CNT_W'(IMG_BEATS - 1)) begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_e_in_valid <= 1'b0;
            // A gap once the image has started is a broken transfer
            if (r_in_cnt != '0) begin
              r_err     <= 1'b1;
              r_discard <= 1'b1;
              r_state   <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          r_e_in_valid <= 1'b0;
          if (e_out_valid) begin
            r_r_valid <= ~r_discard;
            r_r_data  <= e_out_data;
            r_r_id    <= w_sel;
            r_r_last  <= 1'b0;
            r_out_cnt <= OUT_CNT_W'(1);
            r_state   <= ST_DRAIN;
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_gnt   <= '0;
            r_state <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (e_out_valid) begin
            r_r_valid <= ~r_discard;
            r_r_data  <= e_out_data;
            r_r_id    <= w_sel;
            r_r_last  <= w_last_out;
            r_out_cnt <= r_out_cnt + OUT_CNT_W'(1);
            if (w_last_out) begin
              r_gnt   <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_r_valid <= 1'b0;
            r_r_last  <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign e_in_valid = r_e_in_valid;
  assign e_in_data  = r_e_in_data;
  assign e_op       = r_e_op;
  assign r_valid    = r_r_valid;
  assign r_data     = r_r_data;
  assign r_id       = r_r_id;
  assign r_last     = r_r_last;
  assign busy       = (r_state != ST_IDLE);
  assign err        = r_err;

endmodule

`default_nettype wire
